// File: rtl/ins_mem_loader.sv
// ins_mem_loader: boot-time loader that assembles big-endian words from a byte
// stream, writes them to instruction memory and verifies a trailing checksum.
`default_nettype none

module ins_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [15:0] Len,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic [31:0] IAddr,
    output logic [31:0] DataIn,
    output logic        InsWr,
    output logic        CpuRST,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d, idx_inc;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        inswr_q, inswr_d;
    logic        cpurst_q, cpurst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] word;
    logic        xfer;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        iaddr_d = iaddr_q;
        data_d  = data_q;
        word    = {shift_q, ByteIn};
        idx_inc = idx_q + 16'd1;
        // ready_q mirrors the current state, so it doubles as the handshake qualifier
        xfer    = ready_q && ByteValid;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    len_d   = Len;
                    idx_d   = 16'd0;
                    bcnt_d  = 2'd0;
                    shift_d = 24'd0;
                    sum_d   = 32'd0;
                    if ({1'b0, Len} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else if (Len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (xfer) begin
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], ByteIn};
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        data_d  = word;
                        iaddr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                sum_d   = sum_q + data_q;
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                if (xfer) begin
                    bcnt_d  = bcnt_q + 2'd1;
                    shift_d = {shift_q[15:0], ByteIn};
                    if (bcnt_q == 2'd3) begin
                        state_d = (word == sum_q) ? S_DONE : S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they track state_q exactly
        ready_d  = (state_d == S_RECV) || (state_d == S_CHECK);
        inswr_d  = (state_d == S_WRITE);
        busy_d   = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
        done_d   = (state_d == S_DONE);
        cpurst_d = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            len_q    <= 16'd0;
            idx_q    <= 16'd0;
            bcnt_q   <= 2'd0;
            shift_q  <= 24'd0;
            sum_q    <= 32'd0;
            iaddr_q  <= BASE_ADDR;
            data_q   <= 32'd0;
            ready_q  <= 1'b0;
            inswr_q  <= 1'b0;
            cpurst_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            sum_q    <= sum_d;
            iaddr_q  <= iaddr_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            inswr_q  <= inswr_d;
            cpurst_q <= cpurst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ByteReady = ready_q;
    assign IAddr     = iaddr_q;
    assign DataIn    = data_q;
    assign InsWr     = inswr_q;
    assign CpuRST    = cpurst_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

`default_nettype wire

// File: doc/ins_mem_loader.md
# ins_mem_loader

Boot-time program loader for the multi-cycle CPU. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into the instruction memory write port. A trailing checksum word is verified. The CPU is held in reset until the load completes successfully. The loader is the writer side of the instruction memory; the CPU fetch path is the reader.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- MAX_WORDS, 128: capacity of the instruction memory in words; loads longer than this are rejected.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Start  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- Len  in  16  number of instruction words; latched when Start is accepted.
- ByteIn  in  8  stream data.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- IAddr  out  32  instruction memory byte address.
- DataIn  out  32  instruction word to write.
- InsWr  out  1  write strobe, active-high, one cycle per word.
- CpuRST  out  1  active-low reset to the CPU.
- Busy  out  1  high in RECV, WRITE and CHECK.
- Done  out  1  load completed with a matching checksum.
- Err  out  1  load rejected: length overflow or checksum mismatch.

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE, ERR.
- IDLE: ByteReady=0. On Start:
  - Len > MAX_WORDS -> ERR.
  - Len == 0 -> CHECK.
  - otherwise -> RECV.
  - On any accepted Start, idx, byte counter and sum are cleared.
- RECV: ByteReady=1. A byte transfers when ByteValid && ByteReady.
  - Bytes fill the shift word MSB-first: the first byte goes to bits [31:24].
  - On the 4th byte -> WRITE.
- WRITE: lasts exactly one cycle.
  - InsWr=1, IAddr=BASE_ADDR+4*idx, DataIn=assembled word, ByteReady=0.
  - sum += word, modulo 2^32.
  - idx++. If the new idx == Len -> CHECK, else -> RECV.
- CHECK: ByteReady=1. Receives 4 bytes MSB-first.
  - On the 4th byte, compare with sum: equal -> DONE, else -> ERR.
- DONE: Done=1, CpuRST=1. Start restarts the load (-> RECV/CHECK/ERR as in IDLE) and drives CpuRST low again.
- ERR: Err=1, CpuRST=0. Only Start or RST leaves ERR.
- Start asserted while Busy is ignored.
- ByteValid outside RECV/CHECK is ignored; no byte is consumed.

## Timing
- Reset values: state=IDLE, ByteReady=0, IAddr=BASE_ADDR, DataIn=0, InsWr=0, CpuRST=0, Busy=0, Done=0, Err=0.
- Reset asserted mid-load aborts immediately. A word already written stays in memory; a partial word is discarded.
- Minimum cost per word is 5 cycles: 4 byte cycles plus 1 WRITE cycle. ByteReady drops for that WRITE cycle.
- Stalls (ByteValid=0) may occur anywhere and hold all state.
- Transitions:
  - Done/Err rise the cycle after the final checksum byte.
  - CpuRST rises with Done.
  - Err rises the cycle after a Start with overflow.
- IAddr and DataIn hold their last written values outside WRITE.
- idx is 16 bits. IAddr = BASE_ADDR + {idx,2'b00}, computed in 32 bits; wrap-around is impossible because Len ≤ MAX_WORDS.
- Len == MAX_WORDS is legal. Len == MAX_WORDS+1 is an overflow.

## Test plan
- Reset then Start, Len=2, bytes 20 01 00 05 | 00 00 00 00 | 20 01 00 05 -> InsWr pulses at IAddr 0 (DataIn 32'h20010005) and 4 (32'h00000000); Done=1, CpuRST=1.
- Same stream with checksum 20 01 00 06 -> Err=1, CpuRST stays 0, Done=0.
- Start with Len=MAX_WORDS+1 -> Err=1 next cycle, ByteReady never asserts, no InsWr.
- Start with Len=0 followed by bytes 00 00 00 00 -> no InsWr, Done=1.
- Len=3 with random ByteValid gaps and a Start pulse mid-load -> Start ignored, 3 writes at addresses 0/4/8, correct sum, Done.
- RST pulsed low after 6 bytes of a Len=2 load -> all outputs at reset values immediately; new load from Start succeeds at IAddr 0.
